// File: rtl/multiplier_3b_if.sv
// Operand/result bundle for the sequential shift-and-add multiplier.
//   master : drives init, MulA, MulB; observes ResultM, done, busy
//   slave  : the multiplier side of the same bundle
interface multiplier_3b_if #(
  parameter int unsigned WIDTH = 3
);
  logic               init;
  logic [WIDTH-1:0]   MulA;
  logic [WIDTH-1:0]   MulB;
  logic [2*WIDTH-1:0] ResultM;
  logic               done;
  logic               busy;

  modport master (
    output init, MulA, MulB,
    input  ResultM, done, busy
  );

  modport slave (
    input  init, MulA, MulB,
    output ResultM, done, busy
  );
endinterface

// File: rtl/multiplier_3b.sv
// Sequential unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Shares the init/done handshake of the ALU divider: init sampled in IDLE
// starts an operation, done/ResultM appear WIDTH edges later, and done is
// held until init is seen low.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of multiplier_3b_if (init, MulA, MulB in;
//           ResultM, done, busy out, all registered)
module multiplier_3b #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  multiplier_3b_if.slave   bus
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    m;
  logic [WIDTH-1:0] q;
  logic [PW-1:0]    p;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    result;
  logic             done_r;
  logic             busy_r;

  // Accumulator value after the current iteration's conditional add.
  logic [PW-1:0] p_sum_c;
  assign p_sum_c = q[0] ? (p + m) : p;

  // Control and datapath; fixed WIDTH iterations, no early exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      m      <= '0;
      q      <= '0;
      p      <= '0;
      cnt    <= '0;
      result <= '0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.init) begin
            m      <= PW'(bus.MulA);
            q      <= bus.MulB;
            p      <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          p   <= p_sum_c;
          m   <= m << 1;
          q   <= q >> 1;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            // ResultM only ever takes a completed product.
            result <= p_sum_c;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          // Hold done until init is released; no auto-restart.
          if (!bus.init) begin
            done_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ResultM = result;
  assign bus.done    = done_r;
  assign bus.busy    = busy_r;

endmodule

// File: tb/tb_multiplier_3b.sv
// Self-checking bench for multiplier_3b (WIDTH=3 main instance, WIDTH=4 spot
// instance). Expected values come from plain arithmetic and a fixed-latency
// timeline model.
module tb_multiplier_3b;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  // Model of the last completed product held on each instance's ResultM.
  int   last3;
  int   last4;

  multiplier_3b_if #(.WIDTH(3)) bus3 ();
  multiplier_3b_if #(.WIDTH(4)) bus4 ();

  multiplier_3b #(.WIDTH(3), .CNT_W(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  multiplier_3b #(.WIDTH(4), .CNT_W(3)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One WIDTH=3 operation, starting at a falling edge with the DUT in IDLE.
  task automatic run3(input int a, input int b, input bit hold);
    bus3.MulA = 3'(a);
    bus3.MulB = 3'(b);
    bus3.init = 1'b1;
    @(posedge clk);   // edge 0
    @(negedge clk);
    if (!hold) bus3.init = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("calc_busy", 32'(bus3.busy), 32'd1);
      check("calc_done", 32'(bus3.done), 32'd0);
      check("calc_res_stable", 32'(bus3.ResultM), 32'(last3));
      // Operand changes during CALC must not matter.
      bus3.MulA = 3'($urandom_range(7, 0));
      bus3.MulB = 3'($urandom_range(7, 0));
      step();
    end
    last3 = a * b;
    check("done_set", 32'(bus3.done), 32'd1);
    check("done_busy", 32'(bus3.busy), 32'd0);
    check("product", 32'(bus3.ResultM), 32'(last3));
    if (hold) begin
      step();
      check("done_held", 32'(bus3.done), 32'd1);
      check("held_res", 32'(bus3.ResultM), 32'(last3));
      bus3.init = 1'b0;
    end
    step();
    check("done_clear", 32'(bus3.done), 32'd0);
    check("idle_busy", 32'(bus3.busy), 32'd0);
    check("idle_res", 32'(bus3.ResultM), 32'(last3));
  endtask

  // One WIDTH=4 operation with an init pulse.
  task automatic run4(input int a, input int b);
    bus4.MulA = 4'(a);
    bus4.MulB = 4'(b);
    bus4.init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.init = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("w4_busy", 32'(bus4.busy), 32'd1);
      check("w4_res_stable", 32'(bus4.ResultM), 32'(last4));
      step();
    end
    last4 = a * b;
    check("w4_done", 32'(bus4.done), 32'd1);
    check("w4_product", 32'(bus4.ResultM), 32'(last4));
    step();
    check("w4_done_clear", 32'(bus4.done), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    last3 = 0;
    last4 = 0;
    reset = 1'b1;
    bus3.init = 1'b0; bus3.MulA = '0; bus3.MulB = '0;
    bus4.init = 1'b0; bus4.MulA = '0; bus4.MulB = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_res", 32'(bus3.ResultM), 32'd0);
    check("rst_done", 32'(bus3.done), 32'd0);
    check("rst_busy", 32'(bus3.busy), 32'd0);
    reset = 1'b0;

    // Idle with init low: nothing moves.
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle5_res", 32'(bus3.ResultM), 32'd0);
      check("idle5_done", 32'(bus3.done), 32'd0);
      check("idle5_busy", 32'(bus3.busy), 32'd0);
    end

    run3(7, 7, 1'b1);   // 49, init held through DONE
    run3(5, 0, 1'b0);   // zero multiplier
    run3(0, 6, 1'b0);   // zero multiplicand
    run3(3, 6, 1'b0);   // 18, operands scrambled during CALC

    // Reset one cycle after start aborts the operation immediately.
    bus3.MulA = 3'd6;
    bus3.MulB = 3'd5;
    bus3.init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus3.init = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    last3 = 0;
    last4 = 0;
    check("abort_res", 32'(bus3.ResultM), 32'd0);
    check("abort_busy", 32'(bus3.busy), 32'd0);
    check("abort_done", 32'(bus3.done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_abort_res", 32'(bus3.ResultM), 32'd0);
      check("post_abort_done", 32'(bus3.done), 32'd0);
      check("post_abort_busy", 32'(bus3.busy), 32'd0);
    end
    run3(2, 3, 1'b0);   // 6

    // Exhaustive sweep of all operand pairs.
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        run3(a, b, 1'($urandom_range(1, 0)));

    // Random extra operations.
    for (int i = 0; i < 20; i++)
      run3(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)), 1'($urandom_range(1, 0)));

    // WIDTH=4 spot checks.
    run4(15, 15);
    run4(9, 13);
    run4(0, 11);
    for (int i = 0; i < 6; i++)
      run4(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
